// File: rtl/shift_add_mult.sv
// Sequential shift-and-add unsigned multiplier with start/ready input handshake
// and valid/ready output handshake; product is held stable between completions.
module shift_add_mult #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           in_ready,
    output logic [2*N-1:0] product,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] a_reg;
    logic [2*N-1:0] sum;
    logic [N-1:0]   b_reg;
    logic [CW-1:0]  count;
    logic           last;

    // Accumulator value including this cycle's conditional add; on the final
    // CALC cycle this is the finished product.
    assign sum  = acc + (b_reg[0] ? a_reg : '0);
    assign last = (count == CW'(N - 1));

    assign in_ready = (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = CALC;
            CALC:    if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // product is written only on the completing CALC edge so the downstream
    // display never sees partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            count     <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= {{N{1'b0}}, a};
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= sum;
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    count <= count + CW'(1);
                    if (last) begin
                        product   <= sum;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential shift-and-add unsigned multiplier producing the 2N-bit binary product consumed by the binary-to-BCD converter. With the default N=4, its 8-bit `product` drives the converter's 8-bit `indata` directly. It accepts one operand pair per transaction through a start/ready handshake and computes the product in N clock cycles. It holds the last result stable on `product` so the downstream BCD/display path never sees intermediate values.

## Interface
- N, 4: operand width in bits; product width is 2N. Default N=4 makes `product` 8 bits, the converter's input width.
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when `in_ready`=1.
- a  input  N  multiplicand, unsigned.
- b  input  N  multiplier, unsigned.
- in_ready  output  1  high in IDLE only.
- product  output  2N  registered result of the last completed multiplication.
- out_valid  output  1  high while a fresh product awaits acceptance.
- out_ready  input  1  downstream acceptance of `product`.

## Operation
- Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, product=0, acc=0, a_reg=0, b_reg=0, count=0.
- States: IDLE, CALC, DONE. `in_ready` = (state==IDLE).
- IDLE:
  - start=1 at an edge: a_reg<={N'b0,a} (2N wide), b_reg<=b, acc<=0, count<=0, go to CALC.
  - start=0: stay.
- CALC, each edge:
  - if b_reg[0]: acc<=acc+a_reg (2N-bit add, never overflows).
  - a_reg<=a_reg<<1; b_reg<=b_reg>>1; count<=count+1.
  - On the edge where count==N-1: product<=final sum (acc plus the last conditional add), out_valid<=1, go to DONE.
- DONE: out_valid=1 and product held.
  - out_ready=1 at an edge: out_valid<=0, go to IDLE.
  - out_ready=0: stay indefinitely (backpressure).
- `start` is ignored in CALC and DONE. Operands are captured only at acceptance, so changes on a/b after acceptance have no effect.
- No early termination: zero operands still take N CALC cycles.
- `product` changes only on the completing CALC edge and on reset. It is stable at all other times, including IDLE and during a following CALC.
- count width: ceil(log2(N))+1 bits. The count value is not visible on any output.

## Timing
- Acceptance edge E0 (IDLE, start=1). CALC occupies edges E1..EN. out_valid and the new product appear after edge EN.
- Latency: N cycles from acceptance to out_valid (4 for the default N).
- in_ready drops after E0 and rises after the edge at which out_ready is sampled high in DONE.
- Minimum transaction period: N+2 cycles (accept, N calc, DONE with out_ready=1 immediately; IDLE must be re-entered before the next start).
- out_valid and out_ready both high at an edge means the transfer completes at that edge. Downstream must capture `product` no later than that edge.
- Reset asserted mid-CALC or in DONE: immediate return to the reset values. The in-flight transaction is discarded and no out_valid pulse appears.
- Reset release: the first start can be accepted at the first rising edge with rst_n=1.
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.

## Test plan
- a=15, b=15, start pulse in IDLE, out_ready=1 -> out_valid rises exactly 4 cycles after acceptance with product=8'hE1 (225). It falls after one cycle and in_ready returns high.
- a=0, b=9, then a=9, b=0 -> product=0 both times, and each still takes 4 cycles to out_valid.
- a=12, b=11 with out_ready=0 for 10 cycles -> product=8'h84 (132) held with out_valid=1 and in_ready=0 throughout. Repeated start pulses during the hold are ignored. Raising out_ready completes the transfer and returns to IDLE.
- Previous product=8'h84, then a=3, b=5 accepted -> product stays 8'h84 through all CALC cycles and changes to 8'h0F only on the completing edge. a/b are toggled randomly during CALC with no effect on the result.
- Reset pulse during the third CALC cycle -> all outputs go to reset values asynchronously, there is no out_valid pulse, and a new transaction (7*6) then yields 8'h2A.
- Exhaustive sweep of all 256 operand pairs, each result fed through the converter -> product equals a*b, and the converter's hundreds/tens/ones match the decimal digits of a*b.
